pla_sweep_checker: RTL and testbench



---
 rtl/pla_sweep_checker.sv | 143 ++++++++++++++
 tb/tb_pla_sweep_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_sweep_checker.sv
// Exhaustive sweep generator and response compactor for a single-output PLA block.
// Optional macro PLA_SWEEP_HOLD_EN adds a hold input that pauses the sweep in place.
module pla_sweep_checker #(
    parameter int unsigned NUM_IN = 14,
    parameter int unsigned SIG_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [NUM_IN-1:0] x,
    input  logic              y,
`ifdef PLA_SWEEP_HOLD_EN
    input  logic              hold,
`endif
    output logic              busy,
    output logic              done,
    output logic [NUM_IN:0]   onset_count,
    output logic [NUM_IN-1:0] first_on,
    output logic              found_on,
    output logic [SIG_W-1:0]  signature
);

    // Polynomial is CRC-CCITT; only SIG_W = 16 is meaningful.
    localparam logic [SIG_W-1:0]  CRC_POLY = SIG_W'(16'h1021);
    localparam logic [NUM_IN-1:0] X_LAST   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_IN-1:0]   r_x;
    logic                r_busy;
    logic                r_done;
    logic [NUM_IN:0]     r_onset;
    logic [NUM_IN-1:0]   r_first;
    logic                r_found;
    logic [SIG_W-1:0]    r_sig;

    state_t              w_state;
    logic [NUM_IN-1:0]   w_x;
    logic                w_busy;
    logic                w_done;
    logic [NUM_IN:0]     w_onset;
    logic [NUM_IN-1:0]   w_first;
    logic                w_found;
    logic [SIG_W-1:0]    w_sig;
    logic                w_step;
    logic                w_fb;

    // A sweep cycle consumes y only when not paused.
`ifdef PLA_SWEEP_HOLD_EN
    assign w_step = (r_state == SWEEP) && !hold;
`else
    assign w_step = (r_state == SWEEP);
`endif

    assign w_fb = r_sig[SIG_W-1] ^ y;

    // Next-state and next-result logic.
    always_comb begin
        w_state = r_state;
        w_x     = r_x;
        w_busy  = r_busy;
        w_done  = r_done;
        w_onset = r_onset;
        w_first = r_first;
        w_found = r_found;
        w_sig   = r_sig;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state = SWEEP;
                    w_x     = '0;
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                    w_onset = '0;
                    w_first = '0;
                    w_found = 1'b0;
                    w_sig   = '0;
                end
            end
            SWEEP: begin
                if (w_step) begin
                    w_onset = r_onset + (NUM_IN + 1)'(y);
                    if (y && !r_found) begin
                        w_first = r_x;
                        w_found = 1'b1;
                    end
                    w_sig = {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
                    if (r_x == X_LAST) begin
                        w_state = DONE;
                        w_x     = '0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_x = r_x + NUM_IN'(1);
                    end
                end
            end
            default: begin
                w_state = IDLE;
                w_x     = '0;
                w_busy  = 1'b0;
                w_done  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_onset <= '0;
            r_first <= '0;
            r_found <= 1'b0;
            r_sig   <= '0;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_onset <= w_onset;
            r_first <= w_first;
            r_found <= w_found;
            r_sig   <= w_sig;
        end
    end

    assign x           = r_x;
    assign busy        = r_busy;
    assign done        = r_done;
    assign onset_count = r_onset;
    assign first_on    = r_first;
    assign found_on    = r_found;
    assign signature   = r_sig;

endmodule

// File: tb/tb_pla_sweep_checker.sv
// Scoreboard bench for pla_sweep_checker: randomized sweeps against a truth-table model.
// Define PLA_SWEEP_HOLD_EN to also exercise the hold pause.
module tb_pla_sweep_checker;

    localparam int N  = 14;
    localparam int SW = 16;
    localparam int NV = 1 << N;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          y;
    logic [N-1:0]  x;
    logic          busy;
    logic          done;
    logic [N:0]    onset_count;
    logic [N-1:0]  first_on;
    logic          found_on;
    logic [SW-1:0] signature;
`ifdef PLA_SWEEP_HOLD_EN
    logic          hold = 1'b0;
`endif

    int           mode = 0;
    logic [N-1:0] mask = '0;
    int           cyc  = 0;
    int           n_vec  = 0;
    int           n_err  = 0;
    int           n_done = 0;

    typedef struct {
        logic [N:0]    onset;
        logic [N-1:0]  first;
        logic          found;
        logic [SW-1:0] sig;
        int            start_cyc;
        int            edges;
    } exp_t;

    exp_t sbq[$];

    pla_sweep_checker #(.NUM_IN(N), .SIG_W(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .x           (x),
        .y           (y),
`ifdef PLA_SWEEP_HOLD_EN
        .hold        (hold),
`endif
        .busy        (busy),
        .done        (done),
        .onset_count (onset_count),
        .first_on    (first_on),
        .found_on    (found_on),
        .signature   (signature)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function block under test: 0 const0, 1 const1, 2 x[0], 3 all-ones detect, 4 masked parity.
    function automatic logic yfun(input int m, input logic [N-1:0] v, input logic [N-1:0] mk);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return v[0];
            3:       return (v == {N{1'b1}});
            default: return ^(v & mk);
        endcase
    endfunction

    always_comb y = yfun(mode, x, mask);

    // Reference: walk the whole truth table, count onsets and run a serial CRC-CCITT.
    function automatic exp_t model(input int m, input logic [N-1:0] mk, input int held);
        exp_t e;
        logic b;
        logic top;
        e.onset = '0;
        e.first = '0;
        e.found = 1'b0;
        e.sig   = '0;
        for (int v = 0; v < NV; v++) begin
            b = yfun(m, N'(v), mk);
            if (b) begin
                if (!e.found) begin
                    e.first = N'(v);
                    e.found = 1'b1;
                end
                e.onset = e.onset + 1'b1;
            end
            top   = e.sig[SW-1];
            e.sig = e.sig << 1;
            if (top ^ b) e.sig = e.sig ^ 16'h1021;
        end
        e.start_cyc = 0;
        e.edges     = NV + 1 + held;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"},     32'(x), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_onset"}, 32'(onset_count), 32'd0);
        chk({tag, "_first"}, 32'(first_on), 32'd0);
        chk({tag, "_found"}, 32'(found_on), 32'd0);
        chk({tag, "_sig"},   32'(signature), 32'd0);
    endtask

    // Monitor: each rising done pops one expected sweep result.
    initial begin : monitor
        logic pd;
        exp_t e;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !pd) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    chk("onset_count", 32'(onset_count), 32'(e.onset));
                    chk("first_on",    32'(first_on),    32'(e.first));
                    chk("found_on",    32'(found_on),    32'(e.found));
                    chk("signature",   32'(signature),   32'(e.sig));
                    chk("done_busy",   32'(busy),        32'd0);
                    chk("done_x",      32'(x),           32'd0);
                    chk("done_edges",  32'(cyc - e.start_cyc + 1), 32'(e.edges));
                end
                n_done++;
            end
            pd = done;
        end
    end

    // One sweep: optional start re-pulses, optional hold pause, optional reset at abort_at.
    task automatic run(input int m, input logic [N-1:0] mk, input int held,
                       input bit repulse, input int abort_at);
        exp_t e;
        int   d0;
        int   k;
        int   hcnt;
        int   budget;
        int   rv;
        bit   aborted;
        mode = m;
        mask = mk;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        e      = model(m, mk, held);
        d0     = n_done;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        e.start_cyc = cyc;
        if (abort_at < 0) sbq.push_back(e);
        chk("first_vec_x", 32'(x), 32'd0);
        chk("first_busy",  32'(busy), 32'd1);
        k       = 0;
        hcnt    = 0;
        aborted = 1'b0;
        budget  = NV + held + 50;
        rv      = $urandom_range(200, NV - 200);
        while (n_done == d0 && k < budget) begin
            start = 1'b0;
            if (abort_at >= 0 && busy && x == N'(abort_at)) begin
                aborted = 1'b1;
                break;
            end
            if (repulse && busy && (x == N'(100) || x == N'(rv))) start = 1'b1;
`ifdef PLA_SWEEP_HOLD_EN
            if (held > 0 && busy && x == N'(10) && hcnt < held) begin
                hold = 1'b1;
                hcnt++;
            end else begin
                hold = 1'b0;
            end
`endif
            @(negedge clk);
            k++;
        end
        start = 1'b0;
`ifdef PLA_SWEEP_HOLD_EN
        hold = 1'b0;
`endif
        if (aborted) begin
            rst_n = 1'b0;
            start = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            start = 1'b0;
            chk_reset_vals("midrst");
            @(negedge clk);
            chk("midrst_idle_busy", 32'(busy), 32'd0);
            chk("midrst_idle_x",    32'(x),    32'd0);
        end else if (n_done == d0) begin
            chk("done_timeout", 32'(n_done), 32'(d0 + 1));
        end else begin
            @(negedge clk);
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_x",    32'(x),    32'd0);
        end
    endtask

    initial begin : stim
        logic [N-1:0] rmask;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk_reset_vals("reset");

        run(0, '0, 0, 1'b0, -1);
        run(1, '0, 0, 1'b0, -1);
        run(2, '0, 0, 1'b1, -1);
`ifdef PLA_SWEEP_HOLD_EN
        run(2, '0, 10, 1'b0, -1);
`else
        run(2, '0, 0, 1'b0, -1);
`endif
        rmask = N'($urandom) | N'(1);
        run(4, rmask, 0, 1'b0, 5000);
        run(3, '0, 0, 1'b1, -1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
